// File: rtl/main_memory_if.sv
// rtl/main_memory_if.sv - single-outstanding request/acknowledge bus between cache and main memory
interface main_memory_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_ack, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_ack, mem_rdata, mem_err
  );
endinterface

// File: rtl/main_memory.sv
// rtl/main_memory.sv - fixed-latency 64-bit backing memory with IDLE/BUSY/ACK access FSM
// Optional out-of-range detection is built when MEM_BOUNDS_CHECK_EN is defined.
module main_memory #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 8
) (
  input  logic         clk,
  input  logic         rst,
  main_memory_if.slave bus
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t                  state_q;
  logic [7:0]              cnt_q;
  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [63:0]             wdata_q;
  logic                    ready_q;
  logic                    ack_q;
  logic [63:0]             rdata_q;
  logic [DEPTH_LOG2-1:0]   idx_d;
  logic [63:0]             rdata_d;
  logic                    commit_d;

  // Contents start at zero and survive reset; only the access FSM is reset.
  logic [63:0] mem_q [DEPTH] = '{default: '0};

  assign idx_d = bus.mem_addr[DEPTH_LOG2+2:3];

`ifdef MEM_BOUNDS_CHECK_EN
  logic oob_q;
  logic err_q;
  logic oob_d;
  logic unused_addr;

  assign oob_d       = |bus.mem_addr[31:DEPTH_LOG2+3];
  assign unused_addr = ^bus.mem_addr[2:0];
  assign rdata_d     = we_q ? wdata_q : (oob_q ? 64'h0 : mem_q[idx_q]);
  assign commit_d    = (state_q == ACK) && we_q && !oob_q;
  assign bus.mem_err = err_q;
`else
  logic unused_addr;

  // High address bits are simply dropped, so out-of-range addresses alias.
  assign unused_addr = ^{bus.mem_addr[31:DEPTH_LOG2+3], bus.mem_addr[2:0]};
  assign rdata_d     = we_q ? wdata_q : mem_q[idx_q];
  assign commit_d    = (state_q == ACK) && we_q;
  assign bus.mem_err = 1'b0;
`endif

  assign bus.mem_ready = ready_q;
  assign bus.mem_ack   = ack_q;
  assign bus.mem_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 64'h0;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      rdata_q <= 64'h0;
`ifdef MEM_BOUNDS_CHECK_EN
      oob_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.mem_req) begin
            we_q    <= bus.mem_we;
            idx_q   <= idx_d;
            wdata_q <= bus.mem_wdata;
            cnt_q   <= CNT_LOAD;
            ready_q <= 1'b0;
            state_q <= BUSY;
`ifdef MEM_BOUNDS_CHECK_EN
            oob_q   <= oob_d;
`endif
          end
        end
        BUSY: begin
          if (cnt_q == 8'd0) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            rdata_q <= rdata_d;
`ifdef MEM_BOUNDS_CHECK_EN
            err_q   <= oob_q;
`endif
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          ready_q <= 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write lands on the edge leaving ACK; a reset mid-access forces IDLE first, so nothing commits.
  always @(posedge clk) begin
    if (commit_d) begin
      mem_q[idx_q] <= wdata_q;
    end
  end
endmodule
